// File: rtl/alu_pkg.sv
// Shared types and constants for the 4-bit ALU: opcode encoding, width, flag bundle,
// and a behavioural reference function used by the optional embedded properties.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic neg;
        logic ovf;
    } alu_flags_t;

    // Packed so that it lines up bit-for-bit with {RESULT, CARRY, ZERO, NEG, OVF}.
    typedef struct packed {
        logic [ALU_W-1:0] result;
        alu_flags_t       flags;
    } alu_out_t;

    function automatic alu_out_t alu_ref(
        input logic [2:0]       opcode,
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b
    );
        alu_out_t   o;
        logic [ALU_W:0] wide;
        o = '0;
        wide = '0;
        case (alu_op_e'(opcode))
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                o.result = wide[ALU_W-1:0];
                o.flags.carry = wide[ALU_W];
                o.flags.ovf = (a[ALU_W-1] == b[ALU_W-1]) && (o.result[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                o.result = a - b;
                o.flags.carry = (a < b);
                o.flags.ovf = (a[ALU_W-1] != b[ALU_W-1]) && (o.result[ALU_W-1] != a[ALU_W-1]);
            end
            OP_AND: o.result = a & b;
            OP_OR:  o.result = a | b;
            OP_XOR: o.result = a ^ b;
            OP_NOT: o.result = ~a;
            OP_SHL: begin
                o.result = a << 1;
                o.flags.carry = a[ALU_W-1];
            end
            OP_SHR: begin
                o.result = a >> 1;
                o.flags.carry = a[0];
            end
            default: o.result = '0;
        endcase
        o.flags.zero = (o.result == '0);
        o.flags.neg  = o.result[ALU_W-1];
        return o;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational core of the 4-bit ALU: result and status flags from opcode and operands.
module alu_comb
    import alu_pkg::*;
(
    input  logic [2:0]       opcode,
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    output logic [ALU_W-1:0] result,
    output alu_flags_t       flags
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;
    logic           carry;
    logic           ovf;

    // Zero-extended operands: bit ALU_W of the difference is set exactly when a < b.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (alu_op_e'(opcode))
            OP_ADD: begin
                result = sum[ALU_W-1:0];
                carry  = sum[ALU_W];
                ovf    = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            OP_SUB: begin
                result = diff[ALU_W-1:0];
                carry  = diff[ALU_W];
                ovf    = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_SHL: begin
                result = {a[ALU_W-2:0], 1'b0};
                carry  = a[ALU_W-1];
            end
            OP_SHR: begin
                result = {1'b0, a[ALU_W-1:1]};
                carry  = a[0];
            end
            default: result = '0;
        endcase
    end

    always_comb begin
        flags       = '0;
        flags.carry = carry;
        flags.ovf   = ovf;
        flags.zero  = (result == '0);
        flags.neg   = result[ALU_W-1];
    end

endmodule

// File: rtl/alu_4b.sv
// Registered 4-bit ALU: alu_comb followed by async-clear output registers.
// Define ALU_FORMAL_EN to compile in embedded assertions and cover points.
module alu_4b
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic [2:0]       OPCODE,
    input  logic [ALU_W-1:0] OP1,
    input  logic [ALU_W-1:0] OP2,
    output logic [ALU_W-1:0] RESULT,
    output logic             CARRY,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF
);

    logic [ALU_W-1:0] next_result;
    alu_flags_t       next_flags;

    alu_comb u_comb (
        .opcode (OPCODE),
        .a      (OP1),
        .b      (OP2),
        .result (next_result),
        .flags  (next_flags)
    );

    // ZERO clears to 0 in reset even though RESULT is 0000 there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RESULT <= '0;
            CARRY  <= 1'b0;
            ZERO   <= 1'b0;
            NEG    <= 1'b0;
            OVF    <= 1'b0;
        end else begin
            RESULT <= next_result;
            CARRY  <= next_flags.carry;
            ZERO   <= next_flags.zero;
            NEG    <= next_flags.neg;
            OVF    <= next_flags.ovf;
        end
    end

`ifdef ALU_FORMAL_EN
    a_reset_clear: assert property (@(posedge clk)
        !rstn |-> (RESULT == '0 && !CARRY && !ZERO && !NEG && !OVF));

    a_reference: assert property (@(posedge clk) disable iff (!rstn)
        $past(rstn) |->
            ({RESULT, CARRY, ZERO, NEG, OVF} ==
             alu_ref($past(OPCODE), $past(OP1), $past(OP2))));

    a_zero_flag: assert property (@(posedge clk) disable iff (!rstn)
        ZERO == (RESULT == '0));

    a_neg_flag: assert property (@(posedge clk)
        NEG == RESULT[ALU_W-1]);

    for (genvar op = 0; op < 8; op++) begin : g_cover_op
        c_opcode: cover property (@(posedge clk) disable iff (!rstn)
            $past(rstn) && ($past(OPCODE) == 3'(op)));
    end

    c_carry: cover property (@(posedge clk) disable iff (!rstn) CARRY);
    c_ovf:   cover property (@(posedge clk) disable iff (!rstn) OVF);
    c_zero:  cover property (@(posedge clk) disable iff (!rstn) ZERO);
`endif

endmodule

// File: tb/tb_alu_4b.sv
// Self-checking bench for alu_4b: directed cases plus randomized ops against an
// integer-arithmetic reference model.
module tb_alu_4b;

    logic       clk;
    logic       rstn;
    logic [2:0] opcode;
    logic [3:0] op1;
    logic [3:0] op2;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       neg;
    logic       ovf;

    int tests;
    int fails;

    alu_4b dut (
        .clk    (clk),
        .rstn   (rstn),
        .OPCODE (opcode),
        .OP1    (op1),
        .OP2    (op2),
        .RESULT (result),
        .CARRY  (carry),
        .ZERO   (zero),
        .NEG    (neg),
        .OVF    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model on plain integers; returns {R[3:0], C, Z, N, V}.
    function automatic logic [7:0] model(input int op, input int a, input int b);
        int r, c, v, sa, sb;
        r = 0; c = 0; v = 0;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        case (op)
            0: begin r = (a + b) % 16; c = (a + b >= 16) ? 1 : 0;
                     v = (sa + sb > 7 || sa + sb < -8) ? 1 : 0; end
            1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0;
                     v = (sa - sb > 7 || sa - sb < -8) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = a / 8; end
            default: begin r = a / 2; c = a % 2; end
        endcase
        return {r[3:0], c[0], (r == 0), (r >= 8), v[0]};
    endfunction

    function automatic logic [7:0] observed();
        return {result, carry, zero, neg, ovf};
    endfunction

    // Drive at the falling edge, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        opcode = op; op1 = a; op2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        rstn = 1'b0; opcode = 3'b111; op1 = 4'b1111; op2 = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        got = observed();
        tests++;
        if (got !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold: got %b expected %b", got, 8'h00);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        got = observed();
        tests++;
        if (got !== 8'b0111_1000) begin
            fails++;
            $display("FAIL reset_release_shr: got %b expected %b", got, 8'b0111_1000);
        end
    endtask

    task automatic test_add();
        logic [7:0] got;
        apply(3'b000, 4'b0111, 4'b0001);
        got = observed();
        tests++;
        if (got !== 8'b1000_0011) begin
            fails++;
            $display("FAIL add_ovf: got %b expected %b", got, 8'b1000_0011);
        end
        apply(3'b000, 4'b1111, 4'b0001);
        got = observed();
        tests++;
        if (got !== 8'b0000_1100) begin
            fails++;
            $display("FAIL add_wrap: got %b expected %b", got, 8'b0000_1100);
        end
    endtask

    task automatic test_sub();
        logic [7:0] got;
        apply(3'b001, 4'b0011, 4'b0101);
        got = observed();
        tests++;
        if (got !== 8'b1110_1010) begin
            fails++;
            $display("FAIL sub_borrow: got %b expected %b", got, 8'b1110_1010);
        end
        apply(3'b001, 4'b1000, 4'b0001);
        got = observed();
        tests++;
        if (got !== 8'b0111_0001) begin
            fails++;
            $display("FAIL sub_ovf: got %b expected %b", got, 8'b0111_0001);
        end
    endtask

    task automatic test_logic();
        logic [7:0] got;
        logic [7:0] exp_tab [4];
        exp_tab[0] = 8'b1000_0010;
        exp_tab[1] = 8'b1110_0010;
        exp_tab[2] = 8'b0110_0000;
        exp_tab[3] = 8'b0011_0000;
        for (int i = 0; i < 4; i++) begin
            apply(3'(i + 2), 4'b1100, 4'b1010);
            got = observed();
            tests++;
            if (got !== exp_tab[i]) begin
                fails++;
                $display("FAIL logic_op%0d: got %b expected %b", i + 2, got, exp_tab[i]);
            end
        end
    endtask

    task automatic test_shift();
        logic [7:0] got;
        apply(3'b110, 4'b1001, 4'b0110);
        got = observed();
        tests++;
        if (got !== 8'b0010_1000) begin
            fails++;
            $display("FAIL shl: got %b expected %b", got, 8'b0010_1000);
        end
        apply(3'b111, 4'b0001, 4'b1111);
        got = observed();
        tests++;
        if (got !== 8'b0000_1100) begin
            fails++;
            $display("FAIL shr_zero: got %b expected %b", got, 8'b0000_1100);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp;
        int op, a, b;
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(7);
            a  = $urandom_range(15);
            b  = $urandom_range(15);
            apply(3'(op), 4'(a), 4'(b));
            got = observed();
            exp = model(op, a, b);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL random op=%0d a=%0d b=%0d: got %b expected %b", op, a, b, got, exp);
            end
        end
    endtask

    // Outputs must hold the previous result until the edge, then show the new one.
    task automatic test_back_to_back();
        logic [7:0] got, prev, exp;
        int a, b;
        @(negedge clk);
        prev = observed();
        for (int op = 0; op < 8; op++) begin
            a = $urandom_range(15);
            b = $urandom_range(15);
            opcode = 3'(op); op1 = 4'(a); op2 = 4'(b);
            exp = model(op, a, b);
            #1;
            got = observed();
            tests++;
            if (got !== prev) begin
                fails++;
                $display("FAIL b2b_hold op=%0d: got %b expected %b", op, got, prev);
            end
            @(posedge clk);
            #1;
            got = observed();
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL b2b_result op=%0d: got %b expected %b", op, got, exp);
            end
            prev = exp;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got;
        apply(3'b000, 4'b0111, 4'b0001);
        #2;
        rstn = 1'b0;
        #1;
        got = observed();
        tests++;
        if (got !== 8'h00) begin
            fails++;
            $display("FAIL async_clear: got %b expected %b", got, 8'h00);
        end
        @(negedge clk);
        opcode = 3'b011; op1 = 4'b1111; op2 = 4'b1111;
        @(posedge clk);
        #1;
        got = observed();
        tests++;
        if (got !== 8'h00) begin
            fails++;
            $display("FAIL reset_ignores_inputs: got %b expected %b", got, 8'h00);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        got = observed();
        tests++;
        if (got !== model(3, 15, 15)) begin
            fails++;
            $display("FAIL first_after_reset: got %b expected %b", got, model(3, 15, 15));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rstn = 1'b0;
        opcode = '0; op1 = '0; op2 = '0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_shift();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
